spi_shift_ctrl: RTL and testbench
=================================

// Module: spi_shift_ctrl
// PURPOSE
//   Transfer controller and shift engine sitting directly downstream of spi_clkgen.
//   Consumes its pos/neg SCLK edge strobes, drives its enable and last inputs, and
//   shifts one frame of 1..DATA_WIDTH bits out on MOSI while sampling MISO.
//   Frames are started by the register/FIFO side; the frame ends with done_o.
// PARAMETERS
//   DATA_WIDTH  32  max frame length in bits; tx/rx data width
//   LEN_WIDTH   $clog2(DATA_WIDTH)  width of len_i (encodes bits-1)
// PORTS
//   clk_i        in   1           system clock
//   rst_i        in   1           asynchronous reset, active-high
//   start_i      in   1           frame request; accepted only in IDLE
//   tx_data_i    in   DATA_WIDTH  frame payload, low len_i+1 bits used
//   len_i        in   LEN_WIDTH   frame length minus 1 (0 => 1 bit)
//   lsb_first_i  in   1           1: bit 0 first; 0: bit len first
//   cpol_i       in   1           SCLK idle level
//   cpha_i       in   1           0: sample leading edge; 1: sample trailing edge
//   pos_edge_i   in   1           SCLK rising strobe from spi_clkgen
//   neg_edge_i   in   1           SCLK falling strobe from spi_clkgen
//   miso_i       in   1           serial input (already synchronised)
//   clk_en_o     out  1           enable to spi_clkgen (its en_i)
//   last_o       out  1           final-edge flag to spi_clkgen (its last_i)
//   mosi_o       out  1           serial output
//   busy_o       out  1           frame in progress
//   done_o       out  1           one-cycle pulse: frame complete, rx_data_o valid
//   rx_data_o    out  DATA_WIDTH  received frame, right-justified, upper bits 0
// BEHAVIOUR
//   Reset: state IDLE; clk_en_o, last_o, busy_o, done_o, mosi_o = 0; rx_data_o = 0.
//   FSM IDLE -> XFER -> DONE -> IDLE.
//   IDLE: start_i=1 latches tx_data_i, len_i, lsb_first_i, cpol_i, cpha_i; next
//     cycle XFER, busy_o=1, clk_en_o=1, edge_cnt=0. Config inputs ignored while busy.
//   Edges: lead = cpol ? neg_edge_i : pos_edge_i; trail = the other strobe.
//     sample = cpha ? trail : lead; launch = cpha ? lead : trail.
//   MOSI: first bit valid on mosi_o from XFER entry. Each launch edge advances to
//     next bit, except the first lead edge when cpha=1 (bit already presented).
//     After the last bit, mosi_o holds the last bit until IDLE, then 0.
//   MISO: each sample edge stores miso_i into rx shadow at the current bit index.
//   edge_cnt counts every pos/neg strobe, width LEN_WIDTH+2; frame = 2*(len+1) edges.
//   last_o: registered, set when edge_cnt reaches 2*(len+1)-1 strobes and the
//     final strobe arrives (i.e. asserted the cycle after the last SCLK edge);
//     SCLK is then at cpol. Next cycle -> DONE.
//   DONE: one cycle; clk_en_o=0, last_o=0, rx_data_o <= shadow, done_o=1, busy_o=1.
//     Then IDLE, busy_o=0. start_i in DONE ignored (earliest accept: first IDLE cycle).
//   Bit order: msb-first sends/receives index len..0; lsb-first 0..len.
//   rx_data_o changes only in DONE; bits above len forced to 0.
//   pos_edge_i & neg_edge_i simultaneously: illegal, assertion fires.
//   Strobes in IDLE/DONE ignored. rst_i mid-frame: immediate return to reset
//     values; no done_o; rx_data_o cleared.
//   len_i = DATA_WIDTH-1: full width, no index overflow.
// STRUCTURE
//   spi_define.sv: SPI_DATA_WIDTH, SPI_LEN_WIDTH, typedef enum logic[1:0]
//     spi_xfer_state_e {IDLE, XFER, DONE}.
//   Sub-module spi_bit_idx: bit index counter (up/down by lsb_first, load on
//     start, step on launch/sample enable), instanced twice (tx, rx).
//   Flops via register.sv dffr/dffer variants; no latches.
// TESTING (bench instantiates spi_clkgen + spi_shift_ctrl, miso looped to mosi)
//   Mode0, len=7, msb, tx=0xA5 -> MOSI 1,0,1,0,0,1,0,1 on rising; rx=0xA5; done 1 pulse.
//   Mode3, len=15, lsb, tx=0x1234 -> 16 SCLK cycles, SCLK idles 1, rx=0x1234.
//   Mode1, len=0, tx=1 -> exactly 2 SCLK edges, rx_data_o=0x1, last_o then done_o.
//   Mode2, len=31, tx=0xDEADBEEF -> rx=0xDEADBEEF, edge count 64.
//   start_i held during XFER with tx=0xFF -> ignored, single done_o, rx of first frame.
//   rst_i at bit 3 of 8-bit frame -> outputs to reset values next edge; new frame OK.

Source files
------------

// File: rtl/spi_shift_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_shift_ctrl_pkg                                           |
// | Description : Shared constants and transfer-state encoding for the SPI    |
// |               shift controller.                                            |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
package spi_shift_ctrl_pkg;

   localparam int c_SPI_DATA_WIDTH = 32;
   localparam int c_SPI_LEN_WIDTH  = $clog2(c_SPI_DATA_WIDTH);

   // Frame sequencing: IDLE -> XFER -> DONE -> IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } spi_xfer_state_e;

endpackage : spi_shift_ctrl_pkg
`default_nettype wire

// File: rtl/spi_shift_ctrl_bit_idx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_shift_ctrl_bit_idx                                       |
// | Description : Bit index counter for one shift direction. Loads the first  |
// |               bit position of a frame, then walks towards the last one    |
// |               (up for lsb-first, down for msb-first) and parks there.     |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module spi_shift_ctrl_bit_idx #(
   parameter int LEN_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_load,
   input  logic                 i_step,
   input  logic                 i_lsb_first,
   input  logic [LEN_WIDTH-1:0] i_len,
   output logic [LEN_WIDTH-1:0] o_idx,
   output logic                 o_at_end
);

   logic [LEN_WIDTH-1:0] r_idx;

   // The final index is len for lsb-first and 0 for msb-first; it never wraps.
   assign o_at_end = i_lsb_first ? (r_idx == i_len) : (r_idx == '0);
   assign o_idx    = r_idx;

   // Load the first bit position on frame start, otherwise step until the end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
      end else if (i_load) begin
         r_idx <= i_lsb_first ? '0 : i_len;
      end else if (i_step && !o_at_end) begin
         r_idx <= i_lsb_first ? (r_idx + LEN_WIDTH'(1)) : (r_idx - LEN_WIDTH'(1));
      end
   end

endmodule : spi_shift_ctrl_bit_idx
`default_nettype wire

// File: rtl/spi_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_shift_ctrl                                               |
// | Description : SPI frame controller and shift engine. Consumes the SCLK    |
// |               edge strobes of the clock generator, shifts 1..DATA_WIDTH   |
// |               bits out on MOSI and samples MISO into a right-justified    |
// |               receive word presented with a one-cycle done pulse.         |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module spi_shift_ctrl
   import spi_shift_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = c_SPI_DATA_WIDTH,
   parameter int LEN_WIDTH  = c_SPI_LEN_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic                  lsb_first_i,
   input  logic                  cpol_i,
   input  logic                  cpha_i,
   input  logic                  pos_edge_i,
   input  logic                  neg_edge_i,
   input  logic                  miso_i,
   output logic                  clk_en_o,
   output logic                  last_o,
   output logic                  mosi_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] rx_data_o
);

   localparam int c_CNT_WIDTH = LEN_WIDTH + 2;

   spi_xfer_state_e        r_state;
   spi_xfer_state_e        w_state_nxt;
   logic                   w_start_acc;

   logic [DATA_WIDTH-1:0]  r_tx;
   logic [LEN_WIDTH-1:0]   r_len;
   logic                   r_lsb;
   logic                   r_cpol;
   logic                   r_cpha;
   logic [c_CNT_WIDTH-1:0] r_edge_cnt;
   logic                   r_last;
   logic [DATA_WIDTH-1:0]  r_shadow;
   logic [DATA_WIDTH-1:0]  r_rx_data;

   logic                   w_strobe;
   logic                   w_lead;
   logic                   w_trail;
   logic                   w_sample;
   logic                   w_launch;
   logic [c_CNT_WIDTH-1:0] w_final_cnt;
   logic                   w_idx_lsb;
   logic [LEN_WIDTH-1:0]   w_idx_len;
   logic [LEN_WIDTH-1:0]   w_tx_idx;
   logic [LEN_WIDTH-1:0]   w_rx_idx;
   logic                   w_tx_end;
   logic                   w_rx_end;
   logic [DATA_WIDTH-1:0]  w_mask;

   // Strobes only matter during XFER and before the final edge has been seen.
   assign w_strobe = (r_state == ST_XFER) && !r_last && (pos_edge_i || neg_edge_i);
   assign w_lead   = r_cpol ? neg_edge_i : pos_edge_i;
   assign w_trail  = r_cpol ? pos_edge_i : neg_edge_i;
   assign w_sample = w_strobe && (r_cpha ? w_trail : w_lead);
   // With cpha=1 the first leading edge would launch the bit that is already on MOSI.
   assign w_launch = w_strobe && (r_cpha ? w_lead : w_trail)
                     && !(r_cpha && (r_edge_cnt == '0));

   // Index of the final strobe: 2*(len+1)-1 = 2*len+1.
   assign w_final_cnt = {1'b0, r_len, 1'b1};

   // Index counters need the live config on the start cycle, the latched one after.
   assign w_idx_lsb = w_start_acc ? lsb_first_i : r_lsb;
   assign w_idx_len = w_start_acc ? len_i : r_len;

   spi_shift_ctrl_bit_idx #(
      .LEN_WIDTH (LEN_WIDTH)
   ) u_tx_idx (
      .clk         (clk_i),
      .rst         (rst_i),
      .i_load      (w_start_acc),
      .i_step      (w_launch),
      .i_lsb_first (w_idx_lsb),
      .i_len       (w_idx_len),
      .o_idx       (w_tx_idx),
      .o_at_end    (w_tx_end)
   );

   spi_shift_ctrl_bit_idx #(
      .LEN_WIDTH (LEN_WIDTH)
   ) u_rx_idx (
      .clk         (clk_i),
      .rst         (rst_i),
      .i_load      (w_start_acc),
      .i_step      (w_sample),
      .i_lsb_first (w_idx_lsb),
      .i_len       (w_idx_len),
      .o_idx       (w_rx_idx),
      .o_at_end    (w_rx_end)
   );

   // Receive mask: keep bits 0..len, force everything above to zero.
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
      assign w_mask[gi] = (32'(gi) <= 32'(r_len));
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      clk_en_o    = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      mosi_o      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_state_nxt = ST_XFER;
               w_start_acc = 1'b1;
            end
         end
         ST_XFER: begin
            clk_en_o = 1'b1;
            busy_o   = 1'b1;
            mosi_o   = r_tx[w_tx_idx];
            if (r_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            busy_o      = 1'b1;
            done_o      = 1'b1;
            mosi_o      = r_tx[w_tx_idx];
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Frame configuration is captured once per frame and held while busy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tx   <= '0;
         r_len  <= '0;
         r_lsb  <= 1'b0;
         r_cpol <= 1'b0;
         r_cpha <= 1'b0;
      end else if (w_start_acc) begin
         r_tx   <= tx_data_i;
         r_len  <= len_i;
         r_lsb  <= lsb_first_i;
         r_cpol <= cpol_i;
         r_cpha <= cpha_i;
      end
   end

   // Edge counting and the registered final-edge flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_edge_cnt <= '0;
         r_last     <= 1'b0;
      end else if (w_start_acc) begin
         r_edge_cnt <= '0;
         r_last     <= 1'b0;
      end else if (r_state == ST_XFER && r_last) begin
         r_last <= 1'b0;
      end else if (w_strobe) begin
         r_edge_cnt <= r_edge_cnt + c_CNT_WIDTH'(1);
         if (r_edge_cnt == w_final_cnt) begin
            r_last <= 1'b1;
         end
      end
   end

   // Capture MISO into the shadow word; publish it on entry to DONE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_shadow  <= '0;
         r_rx_data <= '0;
      end else begin
         if (w_start_acc) begin
            r_shadow <= '0;
         end else if (w_sample) begin
            r_shadow[w_rx_idx] <= miso_i;
         end
         if (r_state == ST_XFER && r_last) begin
            r_rx_data <= r_shadow & w_mask;
         end
      end
   end

   assign last_o    = r_last;
   assign rx_data_o = r_rx_data;

   // The clock generator never produces both strobes in the same cycle.
   a_no_dual_strobe: assert property (@(posedge clk_i) disable iff (rst_i)
      !(pos_edge_i && neg_edge_i));

endmodule : spi_shift_ctrl
`default_nettype wire

// File: tb/tb_spi_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_shift_ctrl                                            |
// | Description : Self-checking bench for spi_shift_ctrl. A behavioural SCLK  |
// |               strobe source and SPI slave model drive the DUT; results    |
// |               are compared against frame-level expectations.              |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_spi_shift_ctrl;

   localparam int HALF = 3;       // system clocks per SCLK half period
   localparam int LIMIT = 4000;   // cycle budget per frame

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] tx_data_i;
   logic [4:0]  len_i;
   logic        lsb_first_i, cpol_i, cpha_i;
   logic        pos_edge_i, neg_edge_i, miso_i;
   logic        clk_en_o, last_o, mosi_o, busy_o, done_o;
   logic [31:0] rx_data_o;

   spi_shift_ctrl dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .tx_data_i   (tx_data_i),
      .len_i       (len_i),
      .lsb_first_i (lsb_first_i),
      .cpol_i      (cpol_i),
      .cpha_i      (cpha_i),
      .pos_edge_i  (pos_edge_i),
      .neg_edge_i  (neg_edge_i),
      .miso_i      (miso_i),
      .clk_en_o    (clk_en_o),
      .last_o      (last_o),
      .mosi_o      (mosi_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .rx_data_o   (rx_data_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] tx;
      logic [4:0]  len;
      bit          lsb, cpol, cpha;
      logic [31:0] slave;
      logic [31:0] exp_rx;
      logic [31:0] exp_mosi;
      int          exp_edges;
   } vec_t;

   typedef struct {
      logic [31:0] rx;
      logic [31:0] mosi_w;
      int          edges;
      int          done_cnt;
      bit          last_prev;
      bit          sclk_end;
      bit          busy_start;
      bit          timeout;
      bit          aborted;
   } res_t;

   int n_tests = 0;
   int n_fail  = 0;
   int frame_id = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (frame %0d): got 0x%0h, expected 0x%0h", name, frame_id, act, exp);
      end
   endtask

   function automatic logic [31:0] mask(input int len);
      logic [63:0] m;
      m = (64'd1 << (len + 1)) - 64'd1;
      return m[31:0];
   endfunction

   // Word position of the k-th bit on the wire.
   function automatic int wire_pos(input vec_t v, input int k);
      return v.lsb ? k : (int'(v.len) - k);
   endfunction

   function automatic logic sbit(input vec_t v, input int k);
      logic [31:0] s;
      s = v.slave;
      if (k > int'(v.len)) return 1'b0;
      return s[wire_pos(v, k)];
   endfunction

   // Run one frame: behavioural SCLK source plus a slave that shifts v.slave out
   // in the same bit order and captures MOSI at each sampling edge.
   task automatic run_frame(input vec_t v, input bit hold, input bit start_in_done,
                            input int abort_at, output res_t r);
      int k, cnt, cyc, p;
      bit sclk, prev_last, is_lead, is_samp;
      r.rx = '0; r.mosi_w = '0; r.edges = 0; r.done_cnt = 0; r.last_prev = 0;
      r.sclk_end = 0; r.busy_start = 0; r.timeout = 0; r.aborted = 0;
      k = 0; cnt = 0; cyc = 0; sclk = v.cpol; prev_last = 0;
      @(negedge clk_i);
      tx_data_i = v.tx; len_i = v.len; lsb_first_i = v.lsb;
      cpol_i = v.cpol; cpha_i = v.cpha; start_i = 1'b1; miso_i = sbit(v, 0);
      @(negedge clk_i);
      r.busy_start = busy_o;
      if (hold) tx_data_i = 32'hFF;
      else      start_i = 1'b0;
      while (cyc < LIMIT) begin
         pos_edge_i = 1'b0; neg_edge_i = 1'b0;
         if (done_o) begin
            r.done_cnt++;
            r.rx = rx_data_o;
            r.last_prev = prev_last;
            r.sclk_end = sclk;
            start_i = start_in_done;
         end else begin
            if (!busy_o) break;
            if (!hold) start_i = 1'b0;
         end
         prev_last = last_o;
         if (abort_at >= 0 && k == abort_at) begin
            r.aborted = 1;
            break;
         end
         miso_i = sbit(v, k);
         if (clk_en_o && !last_o) begin
            cnt++;
            if (cnt == HALF) begin
               cnt = 0;
               sclk = ~sclk;
               r.edges++;
               if (sclk) pos_edge_i = 1'b1;
               else      neg_edge_i = 1'b1;
               is_lead = (sclk != v.cpol);
               is_samp = v.cpha ? !is_lead : is_lead;
               if (is_samp) begin
                  if (k <= int'(v.len)) begin
                     p = wire_pos(v, k);
                     r.mosi_w[p] = mosi_o;
                  end
                  k++;
               end
            end
         end
         @(negedge clk_i);
         cyc++;
      end
      pos_edge_i = 1'b0; neg_edge_i = 1'b0; start_i = 1'b0;
      r.timeout = (cyc >= LIMIT);
   endtask

   task automatic check_frame(input vec_t v, input res_t r);
      check("timeout",          r.timeout, 0);
      check("busy_after_start", r.busy_start, 1);
      check("rx_data",          r.rx, v.exp_rx);
      check("mosi_bits",        r.mosi_w, v.exp_mosi);
      check("sclk_edges",       r.edges, v.exp_edges);
      check("done_pulses",      r.done_cnt, 1);
      check("last_before_done", r.last_prev, 1);
      check("sclk_idle_level",  r.sclk_end, v.cpol);
      check("mosi_idle",        mosi_o, 0);
      check("busy_idle",        busy_o, 0);
   endtask

   vec_t vecs[5];
   vec_t v;
   res_t r;

   initial begin
      vecs[0] = '{tx:32'h000000A5, len:5'd7,  lsb:0, cpol:0, cpha:0, slave:32'h000000A5,
                  exp_rx:32'h000000A5, exp_mosi:32'h000000A5, exp_edges:16};
      vecs[1] = '{tx:32'h00001234, len:5'd15, lsb:1, cpol:1, cpha:1, slave:32'h00001234,
                  exp_rx:32'h00001234, exp_mosi:32'h00001234, exp_edges:32};
      vecs[2] = '{tx:32'h00000001, len:5'd0,  lsb:0, cpol:0, cpha:1, slave:32'h00000001,
                  exp_rx:32'h00000001, exp_mosi:32'h00000001, exp_edges:2};
      vecs[3] = '{tx:32'hDEADBEEF, len:5'd31, lsb:0, cpol:1, cpha:0, slave:32'hDEADBEEF,
                  exp_rx:32'hDEADBEEF, exp_mosi:32'hDEADBEEF, exp_edges:64};
      vecs[4] = '{tx:32'hFFFFFF5A, len:5'd7,  lsb:1, cpol:0, cpha:0, slave:32'hC3C3C3C3,
                  exp_rx:32'h000000C3, exp_mosi:32'h0000005A, exp_edges:16};

      rst_i = 1'b1; start_i = 1'b0; tx_data_i = '0; len_i = '0;
      lsb_first_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0;
      pos_edge_i = 1'b0; neg_edge_i = 1'b0; miso_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_clk_en", clk_en_o, 0);
      check("reset_last",   last_o, 0);
      check("reset_mosi",   mosi_o, 0);
      check("reset_busy",   busy_o, 0);
      check("reset_done",   done_o, 0);
      check("reset_rx",     rx_data_o, 0);
      rst_i = 1'b0;

      // Directed table.
      for (int i = 0; i < 5; i++) begin
         frame_id = i;
         run_frame(vecs[i], 1'b0, 1'b0, -1, r);
         check_frame(vecs[i], r);
      end

      // start_i held through XFER with a different payload: single frame only.
      frame_id = 100;
      run_frame(vecs[0], 1'b1, 1'b0, -1, r);
      check_frame(vecs[0], r);

      // Reset after three bits of an 8-bit frame, then a clean frame.
      frame_id = 101;
      v = vecs[4];
      run_frame(v, 1'b0, 1'b0, 3, r);
      check("abort_reached", r.aborted, 1);
      rst_i = 1'b1;
      #1;
      check("abort_busy",   busy_o, 0);
      check("abort_clk_en", clk_en_o, 0);
      check("abort_last",   last_o, 0);
      check("abort_done",   done_o, 0);
      check("abort_mosi",   mosi_o, 0);
      check("abort_rx",     rx_data_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      frame_id = 102;
      run_frame(vecs[2], 1'b0, 1'b0, -1, r);
      check_frame(vecs[2], r);

      // start_i asserted only during DONE must not launch a new frame.
      frame_id = 103;
      run_frame(vecs[1], 1'b0, 1'b1, -1, r);
      check_frame(vecs[1], r);
      @(negedge clk_i);
      check("no_start_from_done", busy_o, 0);

      // Randomised frames against the frame-level model.
      for (int i = 0; i < 40; i++) begin
         frame_id = 200 + i;
         v.tx = $urandom;
         v.len = 5'($urandom_range(0, 31));
         v.lsb = 1'($urandom_range(0, 1));
         v.cpol = 1'($urandom_range(0, 1));
         v.cpha = 1'($urandom_range(0, 1));
         v.slave = $urandom;
         v.exp_rx = v.slave & mask(int'(v.len));
         v.exp_mosi = v.tx & mask(int'(v.len));
         v.exp_edges = 2 * (int'(v.len) + 1);
         run_frame(v, 1'b0, 1'b0, -1, r);
         check_frame(v, r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_spi_shift_ctrl
`default_nettype wire
